// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_ctrl : load/store unit controller with range/alignment checks and sub-word RMW
// Rev 1.0
// ============================================================================
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LOAD   = 3'd1;
  localparam logic [2:0] c_RMW_RD = 3'd2;
  localparam logic [2:0] c_STORE  = 3'd3;
  localparam logic [2:0] c_RESP   = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_LO = ADDR_WIDTH'(32'h0200_0000);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_HI = ADDR_WIDTH'(32'h0200_1FFF);

  logic [2:0]            r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_req_err;
  logic                  w_mem_act;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merge;

  // Errors are decided from the live request so the error path skips memory entirely
  always_comb begin
    w_req_err = (req_addr < c_ADDR_LO) || (req_addr > c_ADDR_HI);
    case (req_size)
      2'b01:   if (req_addr[0]) w_req_err = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) w_req_err = 1'b1;
      2'b11:   w_req_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_rd_data[{r_addr[1:0], 3'b000} +: 8];
    w_half = mem_rd_data[{r_addr[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_load = {{(DATA_WIDTH-8){w_byte[7] & ~r_uns}}, w_byte};
      2'b01:   w_load = {{(DATA_WIDTH-16){w_half[15] & ~r_uns}}, w_half};
      default: w_load = mem_rd_data;
    endcase
  end

  always_comb begin
    w_merge = r_word;
    case (r_size)
      2'b00:   w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_word  <= '0;
            r_rdata <= '0;
            r_err   <= w_req_err;
            if (w_req_err)              r_state <= c_RESP;
            else if (!req_we)           r_state <= c_LOAD;
            else if (req_size == 2'b10) r_state <= c_STORE;
            else                        r_state <= c_RMW_RD;
          end
        end
        c_LOAD: begin
          r_rdata <= w_load;
          r_state <= c_RESP;
        end
        c_RMW_RD: begin
          r_word  <= mem_rd_data;
          r_state <= c_STORE;
        end
        c_STORE: r_state <= c_RESP;
        c_RESP:  if (resp_ready) r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign w_mem_act   = (r_state == c_LOAD) || (r_state == c_RMW_RD) || (r_state == c_STORE);
  assign req_ready   = (r_state == c_IDLE);
  assign resp_valid  = (r_state == c_RESP);
  assign resp_rdata  = resp_valid ? r_rdata : '0;
  assign resp_err    = resp_valid & r_err;
  assign mem_wr_en   = (r_state == c_STORE) & r_we;
  assign mem_addr    = w_mem_act ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wr_data = mem_wr_en ? w_merge : '0;

endmodule
`default_nettype wire
